// File: rtl/shift_deser.sv
// ----------------------------------------------------------------------------
// shift_deser
//
// Serial-to-parallel deserializer. Bits arrive on sin, qualified by sin_en,
// and are assembled into a WIDTH-bit word either MSB-first or LSB-first. The
// bit order is chosen by sel on the first bit of a frame and held for the
// rest of that frame. A completed word is handed to a single-entry output
// buffer with a valid/ready handshake; a word that completes while the
// buffer is still full and not being drained is dropped and flagged.
//
// Parameters
//   WIDTH       word length in bits, 2..16
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous active-low reset
//   sin         serial data bit
//   sin_en      bit strobe; sin is sampled only when 1
//   sel         bit order: 01 MSB-first, 10 LSB-first, 00/11 no frame start
//   clear       synchronous abort of the partial frame, also clears overrun
//   dout        assembled word (changes only on a completion load or reset)
//   dout_valid  dout holds a word not yet consumed
//   dout_ready  consumer accept; transfer when dout_valid & dout_ready
//   busy        a partial frame is in progress
//   bit_cnt     bits received in the current frame
//   overrun     sticky: a completed word was dropped
// ----------------------------------------------------------------------------
module shift_deser #(
    parameter int WIDTH = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sin,
    input  logic                         sin_en,
    input  logic [1:0]                   sel,
    input  logic                         clear,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] SEL_MSB = 2'b01;
    localparam logic [1:0] SEL_LSB = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Shift one bit into the current partial word in the requested order.
    // MSB-first pushes toward the top so the first bit ends at WIDTH-1;
    // LSB-first pushes toward the bottom so the first bit ends at bit 0.
    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] cur,
        input logic             bit_in,
        input logic             msb_first
    );
        logic [WIDTH-1:0] res;
        if (msb_first) begin
            res = {cur[WIDTH-2:0], bit_in};
        end else begin
            res = {bit_in, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    state_t              state_r;
    logic                dir_msb_r;
    logic [WIDTH-1:0]    shift_r;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic                busy_r;
    logic [WIDTH-1:0]    dout_r;
    logic                dout_valid_r;
    logic                overrun_r;

    logic                sel_legal_s;
    logic                start_s;
    logic                advance_s;
    logic                complete_s;
    logic                dir_use_s;
    logic [WIDTH-1:0]    word_next_s;

    // Decode frame start / advance / completion and the next shifter value.
    // clear masks every shift so an abort always wins over a strobe.
    always_comb begin
        sel_legal_s = 1'b0;
        start_s     = 1'b0;
        advance_s   = 1'b0;
        complete_s  = 1'b0;
        dir_use_s   = dir_msb_r;

        case (sel)
            SEL_MSB: sel_legal_s = 1'b1;
            SEL_LSB: sel_legal_s = 1'b1;
            default: sel_legal_s = 1'b0;
        endcase

        // The first bit of a frame uses sel directly; later bits use the
        // direction latched at frame start.
        if (state_r == ST_IDLE) begin
            dir_use_s = (sel == SEL_MSB);
            start_s   = sin_en && sel_legal_s && !clear;
        end else begin
            dir_use_s  = dir_msb_r;
            advance_s  = sin_en && !clear;
            complete_s = sin_en && !clear && (bit_cnt_r == CNT_LAST);
        end

        word_next_s = shift_in(shift_r, sin, dir_use_s);
    end

    // Frame FSM, shifter, counter, busy and sticky overrun flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            dir_msb_r <= 1'b0;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else if (clear) begin
            state_r   <= ST_IDLE;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        dir_msb_r <= (sel == SEL_MSB);
                        shift_r   <= word_next_s;
                        bit_cnt_r <= CNT_ONE;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (complete_s) begin
                        // The finished word leaves through the output buffer
                        // (or is dropped); the shifter starts clean.
                        shift_r   <= {WIDTH{1'b0}};
                        bit_cnt_r <= CNT_ZERO;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (dout_valid_r && !dout_ready) begin
                            overrun_r <= 1'b1;
                        end
                    end else if (advance_s) begin
                        shift_r   <= word_next_s;
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    shift_r   <= {WIDTH{1'b0}};
                    bit_cnt_r <= CNT_ZERO;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry output buffer. A completing word loads only when the
    // buffer is empty or being drained on this same edge; a drain with no
    // new word just drops valid and leaves dout as it was. clear does not
    // touch this buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (complete_s && (!dout_valid_r || dout_ready)) begin
            dout_r       <= word_next_s;
            dout_valid_r <= 1'b1;
        end else if (dout_valid_r && dout_ready) begin
            dout_valid_r <= 1'b0;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign bit_cnt    = bit_cnt_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_shift_deser.sv
// ----------------------------------------------------------------------------
// tb_shift_deser
//
// Directed bench for shift_deser with WIDTH=5. Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point, i.e. after
// the edge has settled and well before the next one.
// ----------------------------------------------------------------------------
module tb_shift_deser;

    localparam int WIDTH = 5;

    logic             clock;
    logic             reset;
    logic             sin;
    logic             sin_en;
    logic [1:0]       sel;
    logic             clear;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic [2:0]       bit_cnt;
    logic             overrun;

    int tests;
    int fails;

    shift_deser #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .sin        (sin),
        .sin_en     (sin_en),
        .sel        (sel),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp)
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with no strobe.
    task automatic idle_cycle();
        sin_en = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // One strobed bit.
    task automatic send(input logic b, input logic [1:0] s);
        sin    = b;
        sel    = s;
        sin_en = 1'b1;
        @(posedge clock);
        #1;
        sin_en = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        sin        = 1'b0;
        sin_en     = 1'b0;
        sel        = 2'b00;
        clear      = 1'b0;
        dout_ready = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_dout",    32'(dout),       32'h0);
        check("rst_valid",   32'(dout_valid), 32'h0);
        check("rst_busy",    32'(busy),       32'h0);
        check("rst_bit_cnt", 32'(bit_cnt),    32'h0);
        check("rst_overrun", 32'(overrun),    32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_cycle();
        check("post_rst_busy", 32'(busy), 32'h0);

        // Scenario 1: MSB-first 1,0,1,1,0 -> 10110.
        send(1'b1, 2'b01);
        check("s1_cnt1",  32'(bit_cnt), 32'h1);
        check("s1_busy1", 32'(busy),    32'h1);
        send(1'b0, 2'b01);
        send(1'b1, 2'b01);
        send(1'b1, 2'b01);
        check("s1_cnt4",   32'(bit_cnt),    32'h4);
        check("s1_valid4", 32'(dout_valid), 32'h0);
        send(1'b0, 2'b01);
        check("s1_dout",    32'(dout),       32'h16);
        check("s1_valid",   32'(dout_valid), 32'h1);
        check("s1_cnt0",    32'(bit_cnt),    32'h0);
        check("s1_busy0",   32'(busy),       32'h0);
        check("s1_overrun", 32'(overrun),    32'h0);

        // Drain: valid drops, dout keeps its value.
        dout_ready = 1'b1;
        idle_cycle();
        dout_ready = 1'b0;
        check("drain_valid", 32'(dout_valid), 32'h0);
        check("drain_dout",  32'(dout),       32'h16);

        // Illegal sel while idle starts nothing.
        send(1'b1, 2'b00);
        check("sel00_cnt",  32'(bit_cnt), 32'h0);
        check("sel00_busy", 32'(busy),    32'h0);
        send(1'b1, 2'b11);
        check("sel11_cnt",  32'(bit_cnt), 32'h0);

        // Scenario 2: LSB-first 1,0,1,1,0 -> 01101.
        send(1'b1, 2'b10);
        send(1'b0, 2'b10);
        send(1'b1, 2'b10);
        send(1'b1, 2'b10);
        send(1'b0, 2'b10);
        check("s2_dout",  32'(dout),       32'h0D);
        check("s2_valid", 32'(dout_valid), 32'h1);

        // Scenario 3: second word while buffer full and not ready -> dropped.
        send(1'b1, 2'b01);
        send(1'b1, 2'b01);
        send(1'b1, 2'b01);
        send(1'b0, 2'b01);
        send(1'b0, 2'b01);
        check("s3_dout",    32'(dout),       32'h0D);
        check("s3_overrun", 32'(overrun),    32'h1);
        check("s3_valid",   32'(dout_valid), 32'h1);
        idle_cycle();
        check("s3_sticky",  32'(overrun),    32'h1);

        // clear wins over a strobe and aborts a partial frame.
        send(1'b1, 2'b01);
        send(1'b1, 2'b01);
        check("clr_pre_cnt", 32'(bit_cnt), 32'h2);
        clear = 1'b1;
        send(1'b1, 2'b01);
        clear = 1'b0;
        check("clr_cnt",     32'(bit_cnt),    32'h0);
        check("clr_busy",    32'(busy),       32'h0);
        check("clr_overrun", 32'(overrun),    32'h0);
        check("clr_valid",   32'(dout_valid), 32'h1);
        check("clr_dout",    32'(dout),       32'h0D);

        // Scenario 4: consumer accepts on the completion edge -> replace.
        send(1'b0, 2'b01);
        send(1'b0, 2'b01);
        send(1'b1, 2'b01);
        send(1'b1, 2'b01);
        dout_ready = 1'b1;
        send(1'b1, 2'b01);
        check("s4_dout",    32'(dout),       32'h07);
        check("s4_valid",   32'(dout_valid), 32'h1);
        check("s4_overrun", 32'(overrun),    32'h0);
        idle_cycle();
        dout_ready = 1'b0;
        check("s4_drain_valid", 32'(dout_valid), 32'h0);
        check("s4_drain_dout",  32'(dout),       32'h07);

        // Scenario 5: sel changes mid-frame; direction stays MSB-first.
        send(1'b1, 2'b01);
        send(1'b0, 2'b10);
        send(1'b0, 2'b10);
        send(1'b1, 2'b10);
        send(1'b0, 2'b10);
        check("s5_dout",  32'(dout),       32'h12);
        check("s5_valid", 32'(dout_valid), 32'h1);
        dout_ready = 1'b1;
        idle_cycle();
        dout_ready = 1'b0;

        // Scenario 6: asynchronous reset after three bits.
        send(1'b1, 2'b10);
        send(1'b1, 2'b10);
        send(1'b1, 2'b10);
        check("s6_pre_cnt", 32'(bit_cnt), 32'h3);
        #2;
        reset = 1'b0;
        #1;
        check("s6_rst_cnt",   32'(bit_cnt), 32'h0);
        check("s6_rst_busy",  32'(busy),    32'h0);
        check("s6_rst_dout",  32'(dout),    32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        send(1'b0, 2'b01);
        check("s6_cnt1", 32'(bit_cnt), 32'h1);
        send(1'b1, 2'b01);
        send(1'b0, 2'b01);
        send(1'b1, 2'b01);
        send(1'b1, 2'b01);
        check("s6_dout",    32'(dout),       32'h0B);
        check("s6_valid",   32'(dout_valid), 32'h1);
        check("s6_overrun", 32'(overrun),    32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the word length in bits; legal range 2..16.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sin, input, 1, serial data bit.
REQ-005 SHALL have port sin_en, input, 1, bit strobe; sin is sampled only when sin_en=1.
REQ-006 SHALL have port sel, input, 2, bit order: 01 = MSB-first (shift left, insert at bit 0); 10 = LSB-first (shift right, insert at bit WIDTH-1); 00/11 = hold.
REQ-007 SHALL have port clear, input, 1, synchronous abort of the partial frame.
REQ-008 SHALL have port dout, output, WIDTH, the assembled word.
REQ-009 SHALL have port dout_valid, output, 1; dout holds a word not yet consumed.
REQ-010 SHALL have port dout_ready, input, 1, consumer accept; a transfer occurs when dout_valid=1 and dout_ready=1 on the same edge.
REQ-011 SHALL have port busy, output, 1; a partial frame is in progress.
REQ-012 SHALL have port bit_cnt, output, clog2(WIDTH+1), the number of bits received in the current frame.
REQ-013 SHALL have port overrun, output, 1, a sticky flag set when a completed word was dropped.

Function
REQ-014 SHALL implement two states. IDLE: bit_cnt=0, busy=0. SHIFT: 1 <= bit_cnt <= WIDTH-1, busy=1.
REQ-015 In IDLE, sin_en=1 with sel=01 or 10 SHALL latch sel into an internal frame direction, shift in sin, set bit_cnt=1, and go to SHIFT.
REQ-016 In IDLE, sin_en=1 with sel=00 or 11 SHALL be ignored: no shift, no count change.
REQ-017 In SHIFT, sel SHALL be ignored; every sin_en=1 shifts in the latched frame direction and increments bit_cnt.
REQ-018 The frame SHALL complete on the edge that samples bit number WIDTH. That edge SHALL clear the shifter, set bit_cnt=0 and return to IDLE.
REQ-019 On completion with the output buffer free or consumed on the same edge, dout SHALL load the word and dout_valid SHALL be 1 on the next cycle (latency 1 clock from the last bit edge).
REQ-020 When completion, dout_valid=1 and dout_ready=1 coincide on one edge, the new word SHALL replace the old word, and dout_valid SHALL remain 1.
REQ-021 When completion occurs with dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL remain unchanged, and overrun SHALL be set to 1.
REQ-022 A transfer without a coincident completion SHALL clear dout_valid on that edge; dout SHALL keep its value.
REQ-023 dout SHALL change only on a completion load or on reset.
REQ-024 clear=1 SHALL discard the partial frame (shifter=0, bit_cnt=0, IDLE) and clear overrun. It SHALL have priority over sin_en on the same edge. It SHALL NOT affect dout or dout_valid.
REQ-025 Once set, overrun SHALL remain 1 until clear=1 or reset.
REQ-026 MSB-first order SHALL place the first received bit at dout[WIDTH-1]. LSB-first order SHALL place the first received bit at dout[0].

Reset
REQ-027 reset=0 SHALL immediately, without waiting for a clock edge, force: IDLE, shifter=0, bit_cnt=0, dout=0, dout_valid=0, busy=0, overrun=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame. The first frame after reset release SHALL start fresh at bit_cnt=0.
REQ-029 Outputs SHALL hold their reset values until the first qualifying clock edge after reset=1.

Verification
REQ-030 Scenario 1 (MSB-first word): sel=01, bits 1,0,1,1,0 on consecutive sin_en with dout_ready=0 -> dout=5'b10110, dout_valid=1 one cycle after the 5th bit, overrun=0.
REQ-031 Scenario 2 (LSB-first word): sel=10, bits 1,0,1,1,0 -> dout=5'b01101.
REQ-032 Scenario 3 (overrun): two full words with dout_ready=0 throughout -> dout keeps the first word and overrun=1. Then clear=1 -> overrun=0 and dout_valid still 1.
REQ-033 Scenario 4 (back-to-back): dout_ready=1 on the edge of the 2nd word's last bit -> dout shows the 2nd word, dout_valid stays 1, overrun=0.
REQ-034 Scenario 5 (mid-frame sel change): sel=01 for bit 1, sel=10 for bits 2-5 -> the word is assembled MSB-first. Also, sel=00 while IDLE with sin_en=1 -> bit_cnt stays 0.
REQ-035 Scenario 6 (reset mid-frame): reset=0 after 3 bits, asynchronous to clock -> bit_cnt=0, busy=0, dout=0 with no clock edge. Then 5 new bits -> correct word, with no residue from the earlier bits.
